pc_fetch_sequencer: RTL and testbench
=====================================

# pc_fetch_sequencer

Fetch controller for the 8-bit MIPS MPU. It owns the registered program counter, issues instruction-memory reads with a req/ack handshake, and holds each fetched instruction for decode under valid/ready. It applies sequential increment, absolute jump and PC-relative branch redirects from execute. It drains an in-flight memory read before changing address, and supports halt at instruction boundaries.

## Interface
- PC_W, 8, program counter and memory address width
- INSTR_W, 16, instruction word width
- RESET_PC, 8'h00, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- imem_req  out  1  read request to instruction memory
- imem_addr  out  PC_W  read address, equal to pc while imem_req=1
- imem_ack  in  1  read complete; imem_rdata valid this cycle
- imem_rdata  in  INSTR_W  returned instruction
- instr_valid  out  1  instruction available to decode
- instr  out  INSTR_W  held instruction
- instr_pc  out  PC_W  address of held instruction
- instr_ready  in  1  decode accepts instruction
- redirect  in  1  one-cycle redirect strobe from execute
- redirect_rel  in  1  1 = relative branch, 0 = absolute jump
- redirect_base  in  PC_W  PC of the branch instruction (relative mode only)
- redirect_imm  in  PC_W  jump target, or signed two's-complement branch offset
- halt  in  1  request stop at the next instruction boundary
- halted  out  1  sequencer stopped

## Operation
- States: IDLE, REQ, HOLD, DRAIN, HALT.
- IDLE is entered only on reset. It lasts one cycle, then goes to HALT if halt=1, else REQ.
- REQ: imem_req=1, imem_addr=pc. On imem_ack, capture instr<=imem_rdata and instr_pc<=pc, then go to HOLD. Otherwise stay in REQ.
- HOLD: instr_valid=1. On instr_valid&instr_ready: pc<=pc+1 (mod 2^PC_W, so FF wraps to 00). Then go to HALT if halt=1, else REQ.
- Redirect target: relative = redirect_base+redirect_imm mod 2^PC_W (signed offset). Absolute = redirect_imm.
- Redirect has priority over every other event. pc<=target in all states.
  - In REQ with imem_ack the same cycle: discard rdata and go to REQ.
  - In REQ without imem_ack: go to DRAIN.
  - In HOLD: drop instr_valid, no increment, go to REQ (even if instr_ready=1 the same cycle).
  - In HALT or IDLE: update pc only; state is unchanged.
- DRAIN: imem_req=1 with the old address, held in a separate drain_addr register. On imem_ack, discard data and go to REQ (or HALT if halt=1).
  - A further redirect in DRAIN overwrites pc only.
- HALT: halted=1, imem_req=0, instr_valid=0. When halt=0, go to REQ.
- halt is sampled only at IDLE exit, HOLD handshake, DRAIN completion, and in HALT. It never aborts a read.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0.
- Reset mid-read: all of the above take effect immediately. The memory side must tolerate the dropped request.
- First imem_req is high in the second cycle after rst_n deasserts.
- imem_ack may arrive in the same cycle imem_req rises (zero-wait memory).
- Throughput with zero-wait memory and instr_ready=1: one instruction per 2 cycles (REQ, HOLD).
- Each memory wait state adds one cycle. Each cycle of instr_ready=0 adds one cycle.
- imem_addr is stable from request to ack, including across redirects (via DRAIN).
- instr and instr_pc are stable while instr_valid=1 and not yet accepted.
- Redirect to the first new-address request is 1 cycle (from REQ-with-ack or HOLD), or 1 cycle after the drain ack.

## Structure
- Shared package mpu_pkg:
  - PC_W and INSTR_W constants
  - state enum fetch_state_t {IDLE, REQ, HOLD, DRAIN, HALT}
- One sub-module, pc_next_calc (combinational):
  - inputs: pc, redirect, redirect_rel, redirect_base, redirect_imm, advance
  - output: pc_next, implementing the increment, wrap and relative/absolute add rules
- The FSM, drain_addr and instruction holding registers live in pc_fetch_sequencer.

## Test plan
- Reset, then zero-wait memory returning rdata=addr, instr_ready=1: instr_pc sequence 00,01,02 on every second cycle; first imem_req in the 2nd cycle after reset.
- pc preloaded to FE via absolute redirect, then run sequentially: fetch addresses FE, FF, 00 (wrap).
- In HOLD at instr_pc=10, relative redirect with base=10, imm=8'hFC: held instruction dropped, next imem_addr=0C, no instruction from 11 is issued.
- Memory with 3 wait states; absolute jump to 40 in the first wait cycle of fetch 05: imem_addr stays 05 until ack; that data is never presented; next request is at 40.
- halt=1 held while a fetch is in flight: current instruction is delivered, then halted=1 with imem_req=0. halt released: fetch resumes at the incremented pc.
- Assert rst_n low while in DRAIN: all outputs return to reset values immediately; a clean restart at RESET_PC follows.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared definitions for the 8-bit MIPS MPU: datapath widths and the
// fetch sequencer state encoding.
package mpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch sequencer bus bundle: instruction-memory port, decode port,
// redirect port from execute, and halt control.
interface pc_fetch_sequencer_if
  import mpu_pkg::*;
();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_ready;

  logic               redirect;
  logic               redirect_rel;
  logic [PC_W-1:0]    redirect_base;
  logic [PC_W-1:0]    redirect_imm;

  logic               halt;
  logic               halted;

  // The sequencer side.
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  redirect, redirect_rel, redirect_base, redirect_imm,
    input  halt,
    output halted
  );

  // Memory, decode and execute as seen from outside the sequencer.
  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output redirect, redirect_rel, redirect_base, redirect_imm,
    output halt,
    input  halted
  );

endinterface

// File: rtl/pc_fetch_sequencer_pc_next_calc.sv
// Next program counter: redirect target (absolute or PC-relative) takes
// priority over the sequential increment; all arithmetic wraps mod 2^PC_W.
module pc_next_calc
  import mpu_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  input  logic            redirect_i,
  input  logic            redirect_rel_i,
  input  logic [PC_W-1:0] redirect_base_i,
  input  logic [PC_W-1:0] redirect_imm_i,
  input  logic            advance_i,
  output logic [PC_W-1:0] pc_next_o
);

  logic [PC_W-1:0] target;

  // A two's-complement offset added at PC_W bits gives the signed branch.
  assign target = redirect_rel_i ? (redirect_base_i + redirect_imm_i) : redirect_imm_i;

  // NOTE: assign a default first in always_comb so no path leaves the output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_next_o = pc_i;
    if (redirect_i) begin
      pc_next_o = target;
    end else if (advance_i) begin
      pc_next_o = pc_i + PC_W'(1);
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Instruction fetch controller: owns the PC, issues req/ack reads, holds the
// fetched word for decode, applies redirects and halts at instruction boundaries.
module pc_fetch_sequencer
  import mpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pc_fetch_sequencer_if.master  bus
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    drain_addr_q;
  logic               imem_req_q;
  logic               instr_valid_q;
  logic               halted_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    instr_pc_q;

  logic advance;
  logic capture;

  assign advance = (state_q == HOLD) && bus.instr_ready && !bus.redirect;
  assign capture = (state_q == REQ) && bus.imem_ack && !bus.redirect;

  pc_next_calc u_pc_next_calc (
    .pc_i            (pc_q),
    .redirect_i      (bus.redirect),
    .redirect_rel_i  (bus.redirect_rel),
    .redirect_base_i (bus.redirect_base),
    .redirect_imm_i  (bus.redirect_imm),
    .advance_i       (advance),
    .pc_next_o       (pc_d)
  );

  // Redirect outranks every other event; halt is only looked at on boundaries.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!bus.redirect) state_d = bus.halt ? HALT : REQ;
      REQ: begin
        if (bus.redirect)      state_d = bus.imem_ack ? REQ : DRAIN;
        else if (bus.imem_ack) state_d = HOLD;
      end
      HOLD: begin
        if (bus.redirect)         state_d = REQ;
        else if (bus.instr_ready) state_d = bus.halt ? HALT : REQ;
      end
      DRAIN: if (bus.imem_ack) state_d = bus.halt ? HALT : REQ;
      HALT:  if (!bus.redirect && !bus.halt) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      drain_addr_q  <= RESET_PC;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_req_q    <= (state_d == REQ) || (state_d == DRAIN);
      instr_valid_q <= (state_d == HOLD);
      halted_q      <= (state_d == HALT);
      // Tracks the address in flight so a redirect can move pc while the
      // outstanding read still completes at its original address.
      if (state_q == REQ) begin
        drain_addr_q <= pc_q;
      end
      if (capture) begin
        instr_q    <= bus.imem_rdata;
        instr_pc_q <= pc_q;
      end
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: a memory model with programmable wait
// states and a scoreboard of expected read addresses and delivered instructions.
module tb_pc_fetch_sequencer;
  import mpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_sequencer_if bus ();

  pc_fetch_sequencer #(.RESET_PC(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int waits = 0;
  int mem_cnt = 0;
  int cyc = 0;
  int last_cyc = -1;
  bit rate_chk = 1'b0;
  logic [PC_W-1:0] exp_addr_q[$];
  logic [PC_W-1:0] exp_instr_q[$];
  logic [PC_W-1:0] e_pc;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return {~a, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_fetch(input logic [PC_W-1:0] a, input bit deliver);
    exp_addr_q.push_back(a);
    if (deliver) exp_instr_q.push_back(a);
  endtask

  // Memory model and monitor, sampling mid-cycle after stimulus has settled.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
        if (exp_instr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_instr: got pc %0h expected none", bus.instr_pc);
        end else begin
          e_pc = exp_instr_q.pop_front();
          check("instr_pc", 32'(bus.instr_pc), 32'(e_pc));
          check("instr", 32'(bus.instr), 32'(mem_word(e_pc)));
          if (rate_chk && last_cyc >= 0) check("issue_interval", 32'(cyc - last_cyc), 32'd2);
          last_cyc = cyc;
        end
      end
      if (!rst_n || !bus.imem_req) begin
        bus.imem_ack = 1'b0;
        mem_cnt = 0;
      end else if (mem_cnt == waits) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        mem_cnt = 0;
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read: got addr %0h expected none", bus.imem_addr);
        end else begin
          check("read_addr", 32'(bus.imem_addr), 32'(exp_addr_q.pop_front()));
        end
      end else begin
        bus.imem_ack = 1'b0;
        mem_cnt++;
      end
    end
  end

  task automatic pulse_redirect(input logic rel, input logic [PC_W-1:0] base, input logic [PC_W-1:0] imm);
    bus.redirect      = 1'b1;
    bus.redirect_rel  = rel;
    bus.redirect_base = base;
    bus.redirect_imm  = imm;
    @(negedge clk);
    bus.redirect = 1'b0;
  endtask

  task automatic wait_req(input logic [PC_W-1:0] a, input string name);
    for (int n = 0; n < 64 && !(bus.imem_req && bus.imem_addr == a); n++) @(negedge clk);
    check(name, 32'({bus.imem_req, bus.imem_addr}), 32'({1'b1, a}));
  endtask

  task automatic wait_hold(input logic [PC_W-1:0] a, input string name);
    for (int n = 0; n < 64 && !(bus.instr_valid && bus.instr_pc == a); n++) @(negedge clk);
    check(name, 32'({bus.instr_valid, bus.instr_pc}), 32'({1'b1, a}));
  endtask

  task automatic wait_halted(input logic [PC_W-1:0] a, input string name);
    for (int n = 0; n < 64 && !bus.halted; n++) @(negedge clk);
    check(name, 32'({bus.halted, bus.imem_req, bus.instr_valid, bus.imem_addr}),
          32'({1'b1, 1'b0, 1'b0, a}));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(bus.imem_req), 32'd0);
    check({tag, "_addr"}, 32'(bus.imem_addr), 32'h00);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_instr"}, 32'(bus.instr), 32'h0);
    check({tag, "_instr_pc"}, 32'(bus.instr_pc), 32'h0);
    check({tag, "_halted"}, 32'(bus.halted), 32'd0);
  endtask

  initial begin
    bus.instr_ready   = 1'b1;
    bus.redirect      = 1'b0;
    bus.redirect_rel  = 1'b0;
    bus.redirect_base = '0;
    bus.redirect_imm  = '0;
    bus.halt          = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Sequential run with zero-wait memory, one instruction every two cycles.
    push_fetch(8'h00, 1'b1);
    push_fetch(8'h01, 1'b1);
    push_fetch(8'h02, 1'b1);
    rate_chk = 1'b1;
    rst_n = 1'b1;
    #1;
    check("first_cycle_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    check("second_cycle_req", 32'({bus.imem_req, bus.imem_addr}), 32'({1'b1, 8'h00}));
    wait_hold(8'h02, "hold_02");
    bus.halt = 1'b1;
    wait_halted(8'h03, "halt_after_02");
    rate_chk = 1'b0;

    // Absolute redirect while halted, then run across the FF->00 wrap.
    pulse_redirect(1'b0, 8'h00, 8'hFE);
    check("halt_redirect_pc", 32'({bus.halted, bus.imem_addr}), 32'({1'b1, 8'hFE}));
    push_fetch(8'hFE, 1'b1);
    push_fetch(8'hFF, 1'b1);
    push_fetch(8'h00, 1'b1);
    bus.halt = 1'b0;
    wait_hold(8'h00, "hold_wrap_00");
    bus.halt = 1'b1;
    wait_halted(8'h01, "halt_after_wrap");

    // Relative branch back by 4 while HOLD presents 10, with ready in the same cycle.
    bus.instr_ready = 1'b0;
    pulse_redirect(1'b0, 8'h00, 8'h10);
    push_fetch(8'h10, 1'b0);
    bus.halt = 1'b0;
    wait_hold(8'h10, "hold_10");
    @(negedge clk);
    check("hold_stable", 32'({bus.instr_valid, bus.instr_pc, bus.instr}),
          32'({1'b1, 8'h10, mem_word(8'h10)}));
    push_fetch(8'h0C, 1'b1);
    bus.instr_ready = 1'b1;
    pulse_redirect(1'b1, 8'h10, 8'hFC);
    check("rel_redirect", 32'({bus.imem_req, bus.imem_addr, bus.instr_valid}),
          32'({1'b1, 8'h0C, 1'b0}));
    bus.halt = 1'b1;
    wait_halted(8'h0D, "halt_after_0C");

    // Three wait states; jump to 40 during the first wait cycle of fetch 05.
    waits = 3;
    pulse_redirect(1'b0, 8'h00, 8'h05);
    push_fetch(8'h05, 1'b0);
    push_fetch(8'h40, 1'b1);
    bus.halt = 1'b0;
    wait_req(8'h05, "req_05");
    pulse_redirect(1'b0, 8'h00, 8'h40);
    for (int i = 0; i < 3; i++) begin
      check("drain_addr", 32'({bus.imem_req, bus.imem_addr}), 32'({1'b1, 8'h05}));
      @(negedge clk);
    end
    check("post_drain_req", 32'({bus.imem_req, bus.imem_addr}), 32'({1'b1, 8'h40}));
    // Halt raised while the read of 40 is in flight.
    bus.halt = 1'b1;
    wait_halted(8'h41, "halt_after_40");

    // Release halt: fetch resumes at the incremented pc.
    push_fetch(8'h41, 1'b1);
    bus.halt = 1'b0;
    wait_req(8'h41, "resume_41");
    bus.halt = 1'b1;
    wait_halted(8'h42, "halt_after_41");

    // Reset asserted while draining.
    push_fetch(8'h42, 1'b0);
    bus.halt = 1'b0;
    wait_req(8'h42, "req_42");
    pulse_redirect(1'b0, 8'h00, 8'h80);
    check("in_drain", 32'({bus.imem_req, bus.imem_addr}), 32'({1'b1, 8'h42}));
    rst_n = 1'b0;
    exp_addr_q.delete();
    exp_instr_q.delete();
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    waits = 0;
    push_fetch(8'h00, 1'b1);
    push_fetch(8'h01, 1'b1);
    rst_n = 1'b1;
    #1;
    check("restart_first_cycle", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    check("restart_req", 32'({bus.imem_req, bus.imem_addr}), 32'({1'b1, 8'h00}));
    wait_hold(8'h01, "restart_hold_01");
    bus.halt = 1'b1;
    wait_halted(8'h02, "restart_halt");

    repeat (4) @(negedge clk);
    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    check("instr_queue_drained", 32'(exp_instr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
